alu_exec_unit: RTL

Execute-stage datapath block that sits directly downstream of the ALU controller: it consumes the 4-bit ALU control code plus two 32-bit operands and produces a registered result, a zero flag and a branch-condition flag. Single-cycle operations complete in one cycle. `mult` runs as a 32-iteration shift-add sequence, and during that sequence the block holds off new work via `ready_o`/`stall_o` so the pipeline hazard logic can freeze upstream stages.

---
 rtl/alu_exec_unit.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU datapath. Single-cycle logic/arithmetic/compare ops
// register their result on the accept edge; MULT runs as a WIDTH-iteration
// unsigned shift-add sequence, during which ready_o/stall_o hold off new work.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [3:0]       ctrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             ready_o,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             branch_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_BNEQ = 4'b0011;
    localparam logic [3:0] OP_BGEQ = 4'b0100;
    localparam logic [3:0] OP_BGT  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MULT = 4'b1000;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    // Shift-add working registers (stage p1 = multiply iteration stage)
    logic [WIDTH-1:0] mcand_p1;
    logic [WIDTH-1:0] mplier_p1;
    logic [WIDTH-1:0] acc_p1;
    logic [CNT_W-1:0] cnt_p1;
    logic [WIDTH-1:0] acc_sum;

    logic accept;
    logic is_mult;
    logic last_iter;

    // Single-cycle result; compares treat both operands as two's complement
    function automatic logic [WIDTH-1:0] alu_result(
        input logic [3:0]              op,
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_ADD:  r = a + b;
            OP_SUB,
            OP_BNEQ,
            OP_BGEQ,
            OP_BGT:  r = a - b;
            OP_SLT:  r = {{(WIDTH-1){1'b0}}, (a < b)};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Branch condition; zero for every non-branch code
    function automatic logic alu_branch(
        input logic [3:0]              op,
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b
    );
        logic br;
        case (op)
            OP_BNEQ: br = (a != b);
            OP_BGEQ: br = (a >= b);
            OP_BGT:  br = (a > b);
            default: br = 1'b0;
        endcase
        return br;
    endfunction

    assign accept    = valid_i && (state_q == S_IDLE);
    assign is_mult   = (ctrl_i == OP_MULT);
    assign last_iter = (state_q == S_MUL) && (cnt_p1 == CNT_W'(WIDTH - 1));
    assign acc_sum   = acc_p1 + (mplier_p1[0] ? mcand_p1 : '0);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: enter MUL on a mult accept, leave after the final iteration
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && is_mult) state_d = S_MUL;
            S_MUL:   if (last_iter)         state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from registered state only
    always_comb begin
        ready_o = (state_q == S_IDLE);
        stall_o = (state_q != S_IDLE);
    end

    // Stage p0 -> p1: result/flag/done registers and the iteration counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            done_o   <= 1'b0;
            result_o <= '0;
            zero_o   <= 1'b1;
            branch_o <= 1'b0;
            cnt_p1   <= '0;
        end else begin
            done_o <= 1'b0;
            if (state_q == S_IDLE) begin
                if (accept && is_mult) begin
                    cnt_p1 <= '0;
                end else if (accept) begin
                    result_o <= alu_result(ctrl_i, src1_i, src2_i);
                    zero_o   <= (alu_result(ctrl_i, src1_i, src2_i) == '0);
                    branch_o <= alu_branch(ctrl_i, src1_i, src2_i);
                    done_o   <= 1'b1;
                end
            end else begin
                cnt_p1 <= cnt_p1 + 1'b1;
                if (last_iter) begin
                    result_o <= acc_sum;
                    zero_o   <= (acc_sum == '0);
                    branch_o <= 1'b0;
                    done_o   <= 1'b1;
                end
            end
        end
    end

    // Shift-add datapath: latch operands on a mult accept, iterate while in MUL
    always_ff @(posedge clk_i) begin
        if (state_q == S_IDLE) begin
            if (accept && is_mult) begin
                mcand_p1  <= src1_i;
                mplier_p1 <= src2_i;
                acc_p1    <= '0;
            end
        end else begin
            acc_p1    <= acc_sum;
            mcand_p1  <= mcand_p1 << 1;
            mplier_p1 <= mplier_p1 >> 1;
        end
    end

endmodule
